u765_dpram_be: RTL and testbench

//  Parametrised true-dual-port RAM for FDC sector/track buffering: one clock, per-port byte enables,

---
 rtl/u765_mem_pkg.sv | 14 +
 rtl/u765_dpram_lane.sv | 49 ++++
 rtl/u765_dpram_be.sv | 191 +++++++++++++++++++
 tb/tb_u765_dpram_be.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/u765_mem_pkg.sv
// Shared definitions for the u765 sector/track buffer RAM.
//   RDW_WRITE_FIRST / RDW_READ_FIRST : values for the RDW_MODE parameter
//   clr_state_t                      : zero-fill sequencer states
package u765_mem_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/u765_dpram_lane.sv
// One byte lane of the dual-port buffer: a simple dual-write, dual-read
// array with registered read. The read register always returns the word
// as it was before any write on the same edge (read-first raw data).
// Ports:
//   clock, reset_n        : clock, async active-low reset (read registers only)
//   i_we_a / i_we_b       : lane write enables
//   i_re_a / i_re_b       : read enables; o_q_* holds when low
//   i_addr_a / i_addr_b   : word addresses
//   i_d_a / i_d_b         : lane write data
//   o_q_a / o_q_b         : registered lane read data
module u765_dpram_lane #(
    parameter int ADDRWIDTH = 12,
    parameter int BYTEWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_we_a,
    input  logic                 i_re_a,
    input  logic [ADDRWIDTH-1:0] i_addr_a,
    input  logic [BYTEWIDTH-1:0] i_d_a,
    input  logic                 i_we_b,
    input  logic                 i_re_b,
    input  logic [ADDRWIDTH-1:0] i_addr_b,
    input  logic [BYTEWIDTH-1:0] i_d_b,
    output logic [BYTEWIDTH-1:0] o_q_a,
    output logic [BYTEWIDTH-1:0] o_q_b
);
    localparam int DEPTH = 1 << ADDRWIDTH;

    logic [BYTEWIDTH-1:0] r_mem [0:DEPTH-1];

    // Port B is written first so that port A takes the lane if both target
    // the same word (the top also masks B, this keeps the array consistent).
    always_ff @(posedge clock) begin
        if (i_we_b) r_mem[i_addr_b] <= i_d_b;
        if (i_we_a) r_mem[i_addr_a] <= i_d_a;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_q_a <= '0;
            o_q_b <= '0;
        end else begin
            if (i_re_a) o_q_a <= r_mem[i_addr_a];
            if (i_re_b) o_q_b <= r_mem[i_addr_b];
        end
    end

endmodule

// File: rtl/u765_dpram_be.sv
// True-dual-port byte-enabled buffer between the u765 controller (port A)
// and the host/SD loader (port B). Adds hardware zero-fill, collision
// reporting, selectable read-during-write behaviour and an optional
// output register.
// Ports:
//   clock, reset_n            : clock, async active-low reset
//   init_req                  : pulse to restart the fill (ignored while busy)
//   busy                      : fill in progress, port accesses ignored
//   collision                 : one-cycle pulse after overlapping dual write
//   address_x/data_x/wren_x/byteena_x/rden_x : port x request (x = a, b)
//   q_x / q_valid_x           : port x read data and its valid flag
module u765_dpram_be
    import u765_mem_pkg::*;
#(
    parameter int                   DATAWIDTH  = 16,
    parameter int                   ADDRWIDTH  = 12,
    parameter int                   BYTEWIDTH  = 8,
    parameter int                   RDW_MODE   = 0,
    parameter int                   OUT_REG    = 0,
    parameter int                   INIT_CLEAR = 1,
    parameter logic [BYTEWIDTH-1:0] INIT_VALUE = '0,
    localparam int                  LANES      = DATAWIDTH / BYTEWIDTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 init_req,
    output logic                 busy,
    output logic                 collision,
    input  logic [ADDRWIDTH-1:0] address_a,
    input  logic [DATAWIDTH-1:0] data_a,
    input  logic                 wren_a,
    input  logic [LANES-1:0]     byteena_a,
    input  logic                 rden_a,
    output logic [DATAWIDTH-1:0] q_a,
    output logic                 q_valid_a,
    input  logic [ADDRWIDTH-1:0] address_b,
    input  logic [DATAWIDTH-1:0] data_b,
    input  logic                 wren_b,
    input  logic [LANES-1:0]     byteena_b,
    input  logic                 rden_b,
    output logic [DATAWIDTH-1:0] q_b,
    output logic                 q_valid_b
);
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = '1;

    // ---------------- zero-fill sequencer ----------------
    clr_state_t           r_state, w_state_next;
    logic [ADDRWIDTH-1:0] r_clr_addr, w_clr_addr_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        case (r_state)
            IDLE: begin
                if (init_req && (INIT_CLEAR != 0)) begin
                    w_state_next    = CLEAR;
                    w_clr_addr_next = '0;
                end
            end
            CLEAR: begin
                w_clr_addr_next = r_clr_addr + 1'b1;
                if (r_clr_addr == LAST_ADDR) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    logic w_busy;
    assign w_busy = (r_state == CLEAR);
    assign busy   = w_busy;

    // ---------------- port request qualification ----------------
    logic                 w_rd_a, w_rd_b, w_same_addr;
    logic [LANES-1:0]     w_wmask_a, w_wmask_b, w_overlap, w_we_a, w_we_b;
    logic [ADDRWIDTH-1:0] w_lane_addr_a;
    logic [DATAWIDTH-1:0] w_lane_d_a, w_raw_a, w_raw_b, w_rdata_a, w_rdata_b;

    assign w_rd_a      = rden_a & ~w_busy;
    assign w_rd_b      = rden_b & ~w_busy;
    assign w_wmask_a   = (wren_a && !w_busy) ? byteena_a : '0;
    assign w_wmask_b   = (wren_b && !w_busy) ? byteena_b : '0;
    assign w_same_addr = (address_a == address_b);
    assign w_overlap   = w_same_addr ? (w_wmask_a & w_wmask_b) : '0;

    // The fill borrows port A's write path; B loses any lane A also writes.
    assign w_we_a        = w_busy ? '1 : w_wmask_a;
    assign w_we_b        = w_wmask_b & ~w_overlap;
    assign w_lane_addr_a = w_busy ? r_clr_addr : address_a;
    assign w_lane_d_a    = w_busy ? {LANES{INIT_VALUE}} : data_a;

    // ---------------- read pipeline stage 1 ----------------
    // The lanes return pre-write data; for write-first the lanes this port
    // wrote in the read cycle are patched with the captured write data.
    logic                 r_collision, r_rv_a, r_rv_b;
    logic [LANES-1:0]     r_mrg_mask_a, r_mrg_mask_b;
    logic [DATAWIDTH-1:0] r_mrg_data_a, r_mrg_data_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_collision  <= 1'b0;
            r_rv_a       <= 1'b0;
            r_rv_b       <= 1'b0;
            r_mrg_mask_a <= '0;
            r_mrg_mask_b <= '0;
            r_mrg_data_a <= '0;
            r_mrg_data_b <= '0;
        end else begin
            r_collision <= |w_overlap;
            r_rv_a      <= w_rd_a;
            r_rv_b      <= w_rd_b;
            if (w_rd_a) begin
                r_mrg_mask_a <= (RDW_MODE == RDW_WRITE_FIRST) ? w_wmask_a : '0;
                r_mrg_data_a <= data_a;
            end
            if (w_rd_b) begin
                r_mrg_mask_b <= (RDW_MODE == RDW_WRITE_FIRST) ? w_wmask_b : '0;
                r_mrg_data_b <= data_b;
            end
        end
    end

    assign collision = r_collision;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        u765_dpram_lane #(
            .ADDRWIDTH (ADDRWIDTH),
            .BYTEWIDTH (BYTEWIDTH)
        ) u_lane (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_we_a   (w_we_a[gi]),
            .i_re_a   (w_rd_a),
            .i_addr_a (w_lane_addr_a),
            .i_d_a    (w_lane_d_a[gi*BYTEWIDTH +: BYTEWIDTH]),
            .i_we_b   (w_we_b[gi]),
            .i_re_b   (w_rd_b),
            .i_addr_b (address_b),
            .i_d_b    (data_b[gi*BYTEWIDTH +: BYTEWIDTH]),
            .o_q_a    (w_raw_a[gi*BYTEWIDTH +: BYTEWIDTH]),
            .o_q_b    (w_raw_b[gi*BYTEWIDTH +: BYTEWIDTH])
        );

        assign w_rdata_a[gi*BYTEWIDTH +: BYTEWIDTH] = r_mrg_mask_a[gi]
            ? r_mrg_data_a[gi*BYTEWIDTH +: BYTEWIDTH] : w_raw_a[gi*BYTEWIDTH +: BYTEWIDTH];
        assign w_rdata_b[gi*BYTEWIDTH +: BYTEWIDTH] = r_mrg_mask_b[gi]
            ? r_mrg_data_b[gi*BYTEWIDTH +: BYTEWIDTH] : w_raw_b[gi*BYTEWIDTH +: BYTEWIDTH];
    end

    // ---------------- optional output stage ----------------
    if (OUT_REG != 0) begin : g_oreg
        logic [DATAWIDTH-1:0] r_q_a, r_q_b;
        logic                 r_qv_a, r_qv_b;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_q_a  <= '0;
                r_q_b  <= '0;
                r_qv_a <= 1'b0;
                r_qv_b <= 1'b0;
            end else begin
                r_qv_a <= r_rv_a;
                r_qv_b <= r_rv_b;
                if (r_rv_a) r_q_a <= w_rdata_a;
                if (r_rv_b) r_q_b <= w_rdata_b;
            end
        end

        assign q_a       = r_q_a;
        assign q_b       = r_q_b;
        assign q_valid_a = r_qv_a;
        assign q_valid_b = r_qv_b;
    end else begin : g_direct
        // Lane read registers and merge registers only load on a read,
        // so the combined word holds between reads.
        assign q_a       = w_rdata_a;
        assign q_b       = w_rdata_b;
        assign q_valid_a = r_rv_a;
        assign q_valid_b = r_rv_b;
    end

endmodule

// File: tb/tb_u765_dpram_be.sv
module tb_u765_dpram_be;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int LN = 2;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          init_req = 1'b0;
    logic [AW-1:0] address_a = '0, address_b = '0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic          wren_a = 1'b0, wren_b = 1'b0, rden_a = 1'b0, rden_b = 1'b0;
    logic [LN-1:0] byteena_a = '0, byteena_b = '0;

    logic          busy0, busy1, coll0, coll1, v0a, v0b, v1a, v1b;
    logic [DW-1:0] q0a, q0b, q1a, q1b;

    always #5 clock = ~clock;

    int edges = 0;
    always @(posedge clock) edges <= edges + 1;

    int total = 0;
    int bad = 0;

    // dut0: write-first, latency 1.  dut1: read-first, latency 2.
    u765_dpram_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RDW_MODE(0),
                    .OUT_REG(0), .INIT_CLEAR(1), .INIT_VALUE(8'h00)) dut0 (
        .clock(clock), .reset_n(reset_n), .init_req(init_req), .busy(busy0), .collision(coll0),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .byteena_a(byteena_a),
        .rden_a(rden_a), .q_a(q0a), .q_valid_a(v0a),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .byteena_b(byteena_b),
        .rden_b(rden_b), .q_b(q0b), .q_valid_b(v0b));

    u765_dpram_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RDW_MODE(1),
                    .OUT_REG(1), .INIT_CLEAR(1), .INIT_VALUE(8'h00)) dut1 (
        .clock(clock), .reset_n(reset_n), .init_req(init_req), .busy(busy1), .collision(coll1),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .byteena_a(byteena_a),
        .rden_a(rden_a), .q_a(q1a), .q_valid_a(v1a),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .byteena_b(byteena_b),
        .rden_b(rden_b), .q_b(q1b), .q_valid_b(v1b));

    // ---------------- reference model ----------------
    typedef struct { logic [15:0] d; int due; } exp_t;
    exp_t sb0a[$], sb0b[$], sb1a[$], sb1b[$];

    logic [15:0] mem [DEPTH];
    int          clr_left = 0;
    logic        exp_coll = 1'b0;
    logic [15:0] last_q [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, edges);
        end
    endtask

    function automatic logic [15:0] wr_merge(input logic [15:0] old, input logic [15:0] nw,
                                             input logic [1:0] be);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 2; i++)
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    // Applies the effect of the coming clock edge to the model.
    task automatic model_edge();
        int k;
        logic [15:0] oa, ob;
        k = edges + 1;
        exp_coll = 1'b0;
        if (clr_left > 0) begin
            mem[DEPTH - clr_left] = 16'h0000;
            clr_left--;
            return;
        end
        oa = mem[address_a];
        ob = mem[address_b];
        if (rden_a) begin
            sb0a.push_back('{d: (wren_a ? wr_merge(oa, data_a, byteena_a) : oa), due: k});
            sb1a.push_back('{d: oa, due: k + 1});
        end
        if (rden_b) begin
            sb0b.push_back('{d: (wren_b ? wr_merge(ob, data_b, byteena_b) : ob), due: k});
            sb1b.push_back('{d: ob, due: k + 1});
        end
        if (wren_b) mem[address_b] = wr_merge(mem[address_b], data_b, byteena_b);
        if (wren_a) mem[address_a] = wr_merge(mem[address_a], data_a, byteena_a);
        exp_coll = wren_a && wren_b && (address_a == address_b) && ((byteena_a & byteena_b) != 2'b00);
        if (init_req) clr_left = DEPTH;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        chk("busy0", 32'(busy0), 32'(clr_left > 0));
        chk("busy1", 32'(busy1), 32'(clr_left > 0));
        chk("collision0", 32'(coll0), 32'(exp_coll));
        chk("collision1", 32'(coll1), 32'(exp_coll));
    endtask

    task automatic op(input logic wa, input logic [3:0] aa, input logic [15:0] da, input logic [1:0] ba,
                      input logic ra, input logic wb, input logic [3:0] ab, input logic [15:0] db,
                      input logic [1:0] bb, input logic rb, input logic ini);
        wren_a = wa; address_a = aa; data_a = da; byteena_a = ba; rden_a = ra;
        wren_b = wb; address_b = ab; data_b = db; byteena_b = bb; rden_b = rb;
        init_req = ini;
        tick();
    endtask

    task automatic idle();
        op(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    function automatic int sb_size(input int idx);
        case (idx)
            0: return sb0a.size();
            1: return sb0b.size();
            2: return sb1a.size();
            default: return sb1b.size();
        endcase
    endfunction

    function automatic exp_t sb_pop(input int idx);
        case (idx)
            0: return sb0a.pop_front();
            1: return sb0b.pop_front();
            2: return sb1a.pop_front();
            default: return sb1b.pop_front();
        endcase
    endfunction

    function automatic exp_t sb_peek(input int idx);
        case (idx)
            0: return sb0a[0];
            1: return sb0b[0];
            2: return sb1a[0];
            default: return sb1b[0];
        endcase
    endfunction

    task automatic mon(input int idx, input string nm, input logic v, input logic [15:0] q);
        exp_t e;
        bit   more;
        more = 1'b1;
        while (more) begin
            more = 1'b0;
            if (sb_size(idx) > 0) begin
                e = sb_peek(idx);
                if (e.due < edges) begin
                    e = sb_pop(idx);
                    total++; bad++;
                    $display("FAIL %s missed read: no q_valid at edge %0d, expected data %04h", nm, e.due, e.d);
                    more = 1'b1;
                end
            end
        end
        if (v) begin
            if (sb_size(idx) == 0) begin
                total++; bad++;
                $display("FAIL %s unexpected q_valid at edge %0d: q=%04h, no read outstanding", nm, edges, q);
            end else begin
                e = sb_pop(idx);
                if (e.due != edges) begin
                    total++; bad++;
                    $display("FAIL %s early q_valid at edge %0d, expected at edge %0d", nm, edges, e.due);
                end else begin
                    chk({nm, "_data"}, 32'(q), 32'(e.d));
                end
            end
            last_q[idx] = q;
        end else begin
            chk({nm, "_hold"}, 32'(q), 32'(last_q[idx]));
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) last_q[i] = '0;
        end else begin
            mon(0, "dut0_a", v0a, q0a);
            mon(1, "dut0_b", v0b, q0b);
            mon(2, "dut1_a", v1a, q1a);
            mon(3, "dut1_b", v1b, q1b);
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd1);
        chk("rst_coll0", 32'(coll0), 32'd0);
        chk("rst_coll1", 32'(coll1), 32'd0);
        chk("rst_q0", 32'({q0a, q0b}), 32'd0);
        chk("rst_q1", 32'({q1a, q1b}), 32'd0);
        chk("rst_valid", 32'({v0a, v0b, v1a, v1b}), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       wa, wb, ra, rb, ini, prev_rd;
        logic [3:0] aa, ab;
        int         cnt;

        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs();
        reset_n  = 1'b1;
        clr_left = DEPTH;
        repeat (DEPTH) idle();

        // every word reads back as zero after the fill, on both ports
        for (int i = 0; i < DEPTH; i++)
            op(1'b0, 4'(i), 16'h0, 2'b00, 1'b1, 1'b0, 4'(DEPTH - 1 - i), 16'h0, 2'b00, 1'b1, 1'b0);

        // partial lane write over 0xFFFF -> 0xFF34
        op(1'b1, 4'd3, 16'hFFFF, 2'b11, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0);
        op(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0);
        op(1'b0, 4'd3, 16'h0, 2'b00, 1'b1, 1'b0, 4'd3, 16'h0, 2'b00, 1'b1, 1'b0);
        // overlapping dual write -> 0x1155 and one collision pulse
        op(1'b1, 4'd5, 16'hAA55, 2'b01, 1'b0, 1'b1, 4'd5, 16'h1122, 2'b11, 1'b0, 1'b0);
        op(1'b0, 4'd5, 16'h0, 2'b00, 1'b1, 1'b0, 4'd5, 16'h0, 2'b00, 1'b1, 1'b0);
        // disjoint lanes, same word -> both written, no collision
        op(1'b1, 4'd6, 16'h00AA, 2'b01, 1'b0, 1'b1, 4'd6, 16'hBB00, 2'b10, 1'b0, 1'b0);
        op(1'b0, 4'd6, 16'h0, 2'b00, 1'b1, 1'b0, 4'd6, 16'h0, 2'b00, 1'b1, 1'b0);
        // read during write on A, cross-port read on B
        op(1'b1, 4'd8, 16'h0F0F, 2'b11, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0);
        op(1'b1, 4'd8, 16'hABCD, 2'b11, 1'b1, 1'b0, 4'd8, 16'h0, 2'b00, 1'b1, 1'b0);
        op(1'b0, 4'd8, 16'h0, 2'b00, 1'b1, 1'b0, 4'd8, 16'h0, 2'b00, 1'b1, 1'b0);
        repeat (3) idle();

        // randomized traffic with occasional fills
        prev_rd = 1'b0;
        for (int n = 0; n < 400; n++) begin
            wa = 1'($urandom); wb = 1'($urandom);
            ra = 1'($urandom); rb = 1'($urandom);
            aa = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 2) == 0) ? aa : 4'($urandom_range(0, 15));
            ini = 1'b0;
            if (!ra && !rb && !prev_rd && $urandom_range(0, 39) == 0) ini = 1'b1;
            op(wa, aa, 16'($urandom), 2'($urandom), ra, wb, ab, 16'($urandom), 2'($urandom), rb, ini);
            prev_rd = ra | rb;
        end
        repeat (3) idle();
        for (int g = 0; g < 40 && clr_left > 0; g++) idle();

        // reset in the middle of a fill restarts it from address 0
        for (int i = 0; i < DEPTH; i++)
            op(1'b1, 4'(i), 16'($urandom), 2'b11, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0);
        op(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b1);
        for (int g = 0; g < 40 && clr_left > DEPTH - 7; g++) idle();
        reset_n = 1'b0;
        sb0a.delete(); sb0b.delete(); sb1a.delete(); sb1b.delete();
        #2;
        chk_reset_outputs();
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        clr_left = DEPTH;
        cnt = 0;
        for (int g = 0; g < 40 && busy0; g++) begin
            op(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'(g == 2));
            cnt++;
        end
        chk("restart_busy_cycles", 32'(cnt), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            op(1'b0, 4'(i), 16'h0, 2'b00, 1'b1, 1'b0, 4'(i), 16'h0, 2'b00, 1'b1, 1'b0);
        repeat (4) idle();

        chk("sb_left_dut0_a", 32'(sb0a.size()), 32'd0);
        chk("sb_left_dut0_b", 32'(sb0b.size()), 32'd0);
        chk("sb_left_dut1_a", 32'(sb1a.size()), 32'd0);
        chk("sb_left_dut1_b", 32'(sb1b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
